// File: rtl/md_pkg.sv
// Shared encodings and defaults for the multiply/divide unit, its controller
// and the pipeline registers that feed it.
package md_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef logic [0:0] md_state_t;
  localparam md_state_t ST_IDLE = 1'b0;
  localparam md_state_t ST_RUN  = 1'b1;

  localparam int unsigned MUL_LAT_DEF = 5;
  localparam int unsigned DIV_LAT_DEF = 10;

  function automatic int unsigned max_lat(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/md_unit.sv
// Multi-cycle HI/LO multiply/divide unit: the result is computed at acceptance,
// held in shadow registers and committed to HI/LO after a fixed busy period.
module md_unit
  import md_pkg::*;
#(
  parameter int unsigned MUL_LAT = MUL_LAT_DEF,
  parameter int unsigned DIV_LAT = DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  MD_OP,
  input  logic        cancel,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned CNT_W = $clog2(max_lat(MUL_LAT, DIV_LAT) + 1);

  md_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [63:0]      r_shadow;
  logic             r_commit;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;

  logic             w_busy;
  logic             w_accept;
  logic             w_is_md;
  logic             w_is_div;
  logic             w_div_signed;
  logic [63:0]      w_prod_s;
  logic [63:0]      w_prod_u;
  logic [31:0]      w_a_mag;
  logic [31:0]      w_b_mag;
  logic [31:0]      w_b_den;
  logic [31:0]      w_q_mag;
  logic [31:0]      w_r_mag;
  logic [31:0]      w_quo;
  logic [31:0]      w_rem;
  logic             w_q_neg;
  logic             w_r_neg;
  logic [63:0]      w_result;
  logic [CNT_W-1:0] w_lat;

  assign w_busy       = (r_state == ST_RUN);
  assign w_accept     = start & ~w_busy & ~cancel;
  assign w_is_md      = ~MD_OP[2];
  assign w_is_div     = w_is_md & MD_OP[1];
  assign w_div_signed = (MD_OP == OP_DIV);

  assign w_prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign w_prod_u = {32'd0, A} * {32'd0, B};

  // Signed division via magnitudes; 0x80000000 / -1 wraps back to 0x80000000.
  assign w_a_mag = (w_div_signed && A[31]) ? (~A + 32'd1) : A;
  assign w_b_mag = (w_div_signed && B[31]) ? (~B + 32'd1) : B;
  assign w_b_den = (B == 32'd0) ? 32'd1 : w_b_mag;
  assign w_q_mag = w_a_mag / w_b_den;
  assign w_r_mag = w_a_mag % w_b_den;
  assign w_q_neg = w_div_signed & (A[31] ^ B[31]);
  assign w_r_neg = w_div_signed & A[31];
  assign w_quo   = w_q_neg ? (~w_q_mag + 32'd1) : w_q_mag;
  assign w_rem   = w_r_neg ? (~w_r_mag + 32'd1) : w_r_mag;

  always_comb begin
    w_result = w_prod_u;
    w_lat    = CNT_W'(MUL_LAT);
    case (MD_OP)
      OP_MULT:          w_result = w_prod_s;
      OP_MULTU:         w_result = w_prod_u;
      OP_DIV, OP_DIVU: begin
        w_result = {w_rem, w_quo};
        w_lat    = CNT_W'(DIV_LAT);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_shadow <= '0;
      r_commit <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else if (r_state == ST_IDLE) begin
      if (w_accept) begin
        if (w_is_md) begin
          r_state  <= ST_RUN;
          r_cnt    <= w_lat;
          r_shadow <= w_result;
          // Divide by zero still runs the full latency but leaves HI/LO alone.
          r_commit <= ~(w_is_div && (B == 32'd0));
        end else if (MD_OP == OP_MTHI) begin
          r_hi <= A;
        end else if (MD_OP == OP_MTLO) begin
          r_lo <= A;
        end
      end
    end else begin
      if (r_cnt == CNT_W'(1)) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
        if (r_commit) begin
          r_hi <= r_shadow[63:32];
          r_lo <= r_shadow[31:0];
        end
      end else begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  assign busy     = w_busy;
  assign md_stall = w_busy | (start & w_is_md);
  assign HI       = r_hi;
  assign LO       = r_lo;

endmodule
